// File: rtl/sprite_blitter.sv
// sprite_blitter: copies an SPR_W x SPR_H sprite from a sprite ROM into a
// frame RAM. Pixels are issued one per cycle in raster order, clipped to the
// screen, and skipped when they carry the transparent palette index.
//
// Ports:
//   Clk, Reset     clock, synchronous active-high reset
//   start          one-cycle blit request (honoured only in IDLE)
//   pos_x, pos_y   signed top-left target position (two's complement)
//   spr_base       sprite ROM address of pixel (0,0)
//   rom_addr       sprite ROM read address
//   rom_data       sprite ROM palette index, one cycle after rom_addr
//   write_address  frame RAM write address (ty*SCREEN_W + tx)
//   data_In        frame RAM write data
//   we             frame RAM write enable
//   busy           high in RUN and DRAIN
//   done           one-cycle completion pulse (DONE state)
//
// state | meaning
// IDLE  | waiting for start; position and base are latched on accept
// RUN   | issuing one sprite pixel per cycle
// DRAIN | two cycles letting the last pixels leave the pipeline
// DONE  | completion pulse, returns to IDLE
module sprite_blitter #(
  parameter int         SCREEN_W   = 320,
  parameter int         SCREEN_H   = 240,
  parameter int         SPR_W      = 32,
  parameter int         SPR_H      = 32,
  parameter logic [4:0] TRANSP_IDX = 5'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [15:0] spr_base,
  output logic [15:0] rom_addr,
  input  logic [4:0]  rom_data,
  output logic [18:0] write_address,
  output logic [4:0]  data_In,
  output logic        we,
  output logic        busy,
  output logic        done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          drain_q, drain_d;
  logic [9:0]    pos_x_q, pos_x_d;
  logic [9:0]    pos_y_q, pos_y_d;
  logic [15:0]   rom_addr_q, rom_addr_d;
  logic          issue;

  // Stage 1: target coordinates of the pixel whose ROM read is in flight.
  logic          v1_q;
  logic [11:0]   tx_q, tx_d;
  logic [11:0]   ty_q, ty_d;
  logic          on_screen;

  // Stage 2: registered frame RAM write.
  logic          we_q, we_d;
  logic [18:0]   wa_q, wa_d;
  logic [4:0]    data_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    drain_d    = drain_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    rom_addr_d = rom_addr_q;
    issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          pos_x_d    = pos_x;
          pos_y_d    = pos_y;
          rom_addr_d = spr_base;
          col_d      = '0;
          row_d      = '0;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        // Raster order makes consecutive pixels consecutive ROM addresses.
        rom_addr_d = rom_addr_q + 16'd1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            drain_d = 1'b1;
            state_d = S_DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 1'b0) state_d = S_DONE;
        else                 drain_d = drain_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign-extend before adding so off-screen positions never wrap on-screen.
  assign tx_d = {{2{pos_x_q[9]}}, pos_x_q} + 12'(col_q);
  assign ty_d = {{2{pos_y_q[9]}}, pos_y_q} + 12'(row_q);

  assign on_screen = !tx_q[11] && (tx_q < 12'(SCREEN_W)) &&
                     !ty_q[11] && (ty_q < 12'(SCREEN_H));

  assign we_d = v1_q && on_screen && (rom_data != TRANSP_IDX);
  assign wa_d = 19'(ty_q) * 19'(SCREEN_W) + 19'(tx_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      drain_q    <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      rom_addr_q <= rom_addr_d;
      v1_q       <= issue;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      data_q     <= rom_data;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign write_address = wa_q;
  assign data_In       = data_q;
  assign we            = we_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter SCREEN_W, default 320: frame buffer width in pixels.
REQ-002 Parameter SCREEN_H, default 240: frame buffer height in pixels.
REQ-003 Parameter SPR_W, default 32: sprite width in pixels.
REQ-004 Parameter SPR_H, default 32: sprite height in pixels.
REQ-005 Parameter TRANSP_IDX, default 5'h00: palette index treated as transparent.
REQ-006 Clk  input  1: single clock; all state updates on rising edge.
REQ-007 Reset  input  1: reset, synchronous and active-high.
REQ-008 start  input  1: one-cycle request to blit one sprite.
REQ-009 pos_x  input  10: signed sprite top-left X (two's complement).
REQ-010 pos_y  input  10: signed sprite top-left Y (two's complement).
REQ-011 spr_base  input  16: sprite ROM base address of pixel (0,0).
REQ-012 rom_addr  output  16: sprite ROM read address.
REQ-013 rom_data  input  5: sprite ROM palette index, valid one cycle after rom_addr.
REQ-014 write_address  output  19: frame RAM write address.
REQ-015 data_In  output  5: frame RAM write data (palette index).
REQ-016 we  output  1: frame RAM write enable.
REQ-017 busy  output  1: high while a blit is in progress.
REQ-018 done  output  1: one-cycle pulse at blit completion.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last pixel issued; DRAIN->DONE after 2 cycles; DONE->IDLE unconditionally.
REQ-020 In IDLE with start=1, pos_x, pos_y, spr_base SHALL be latched; later input changes SHALL NOT affect the active blit.
REQ-021 start SHALL be ignored in any state other than IDLE.
REQ-022 RUN issues one pixel per cycle, raster order: col 0..SPR_W-1 inner, row 0..SPR_H-1 outer.
REQ-023 rom_addr SHALL equal spr_base + row*SPR_W + col, modulo 2^16, for the issued pixel.
REQ-024 Pixel issued in cycle k SHALL produce its registered write outputs in cycle k+2 (fixed 2-cycle pipeline).
REQ-025 Target coordinates tx = pos_x+col, ty = pos_y+row computed signed at 11 bits minimum; no truncation before clipping.
REQ-026 we SHALL assert only if 0 <= tx < SCREEN_W, 0 <= ty < SCREEN_H, and rom_data != TRANSP_IDX.
REQ-027 write_address SHALL equal ty*SCREEN_W + tx (19 bits); data_In SHALL equal rom_data for that pixel.
REQ-028 When we=0, write_address and data_In are don't-care.
REQ-029 busy SHALL be high in RUN, DRAIN, and low in IDLE and DONE.
REQ-030 Start accepted in cycle 0: pixel n issued cycle 1+n, last write cycle SPR_W*SPR_H+2, done high exactly in cycle SPR_W*SPR_H+3.
REQ-031 A start in the same cycle as done SHALL be ignored; a start the following cycle (IDLE) SHALL be accepted.
REQ-032 A fully off-screen sprite SHALL run the full sequence with we never asserted and done still pulsed.

Reset
REQ-033 Reset=1 SHALL force IDLE, counters to 0, we=0, busy=0, done=0, rom_addr=0, write_address=0, data_In=0 at the next edge.
REQ-034 Reset mid-blit SHALL abort with no further we pulses and no done pulse; start in the same cycle as Reset SHALL be ignored.

Verification
REQ-035 Sprite ROM all 5'h03, start with pos=(0,0), spr_base=0 -> 1024 writes, addresses 0..31, 320..351, ..., 9920..9951, data 5'h03, done at cycle 1027.
REQ-036 pos=(300,230) -> writes only for col 0..19, row 0..9 (200 writes); first address 73900, none wrap into row 0.
REQ-037 pos=(-8,-4) -> first write at frame address 0 with sprite pixel (col 8,row 4), 24x28=672 writes.
REQ-038 ROM checkerboard of 5'h00/5'h07, pos=(10,10) -> 512 writes, all data 5'h07, none for TRANSP_IDX pixels.
REQ-039 pos=(400,0) -> zero writes, busy high 1026 cycles, done pulse at cycle 1027; second start during busy ignored.
REQ-040 Reset asserted at cycle 100 of a blit -> we=0 and busy=0 from cycle 101, no done; new start at cycle 105 completes normally.
